// File: rtl/pll_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_pkg
// Description : Shared types and constants for the rPLL supervisor/sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_ctrl_pkg;

    localparam int ADJ_W = 4;

    typedef logic [ADJ_W-1:0] adj_code_t;

    // A DUTYDA code of zero is illegal for the rPLL.
    localparam adj_code_t DUTYDA_MIN = adj_code_t'(1);

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        WAIT_LOCK  = 3'd1,
        RUN        = 3'd2,
        STEP       = 3'd3,
        HALT       = 3'd4
    } state_t;

    function automatic adj_code_t clamp_duty(input adj_code_t d);
        return (d < DUTYDA_MIN) ? DUTYDA_MIN : d;
    endfunction

    function automatic adj_code_t duty_step(input adj_code_t cur, input adj_code_t tgt);
        if (cur < tgt) return cur + adj_code_t'(1);
        if (cur > tgt) return cur - adj_code_t'(1);
        return cur;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pll_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl_if
// Description : Four-phase adjustment request bus between host and pll_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface pll_ctrl_if;
    import pll_ctrl_pkg::*;

    logic      adj_req;
    adj_code_t adj_psda;
    adj_code_t adj_dutyda;
    adj_code_t adj_fdly;
    logic      adj_busy;
    logic      adj_ack;

    modport master (
        output adj_req, adj_psda, adj_dutyda, adj_fdly,
        input  adj_busy, adj_ack
    );

    modport slave (
        input  adj_req, adj_psda, adj_dutyda, adj_fdly,
        output adj_busy, adj_ack
    );

endinterface
`default_nettype wire

// File: rtl/pll_lock_filter.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_filter
// Description : Two-flop LOCK synchronizer plus consecutive-high stability counter.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_filter #(
    parameter int LOCK_STABLE = 1024
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_lock,
    input  wire logic i_count_en,
    output logic      o_lock_s,
    output logic      o_lock_ok
);

    localparam int                c_cnt_w      = $clog2(LOCK_STABLE + 1);
    localparam logic [c_cnt_w-1:0] c_stable_max = c_cnt_w'(LOCK_STABLE);

    logic [1:0]         r_sync;
    logic [c_cnt_w-1:0] r_stable;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync   <= 2'b00;
            r_stable <= '0;
        end else begin
            r_sync <= {r_sync[0], i_lock};
            // Any low sample, or leaving the qualification window, restarts the count.
            if (!i_count_en || !r_sync[1]) begin
                r_stable <= '0;
            end else if (r_stable != c_stable_max) begin
                r_stable <= r_stable + c_cnt_w'(1);
            end
        end
    end

    assign o_lock_s  = r_sync[1];
    assign o_lock_ok = (r_stable == c_stable_max) && r_sync[1];

endmodule
`default_nettype wire

// File: rtl/pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pll_ctrl
// Description : rPLL reset/lock supervisor with stepped PSDA/DUTYDA/FDLY adjust.
//               Optional macro PLL_CTRL_RELOCK_EN enables automatic relock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int        RESET_CYCLES = 16,
    parameter int        LOCK_STABLE  = 1024,
    parameter int        LOCK_TIMEOUT = 65535,
    parameter int        STEP_CYCLES  = 8,
    parameter adj_code_t PSDA_INIT    = 4'd0,
    parameter adj_code_t DUTYDA_INIT  = 4'd8,
    parameter adj_code_t FDLY_INIT    = 4'd0
) (
    input  wire logic  clk,
    input  wire logic  reset,
    input  wire logic  pll_lock,
    output logic       pll_reset,
    output adj_code_t  pll_psda,
    output adj_code_t  pll_dutyda,
    output adj_code_t  pll_fdly,
    output logic       ready,
    pll_ctrl_if.slave  adj_if,
    output logic [7:0] relock_cnt,
    output logic       timeout_err
);

    localparam int c_max_ab  = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int c_cnt_max = (c_max_ab > STEP_CYCLES) ? c_max_ab : STEP_CYCLES;
    localparam int c_cnt_w   = $clog2(c_cnt_max + 1);

    localparam logic [c_cnt_w-1:0] c_reset_last   = c_cnt_w'(RESET_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(LOCK_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_step_last    = c_cnt_w'(STEP_CYCLES - 1);

`ifdef PLL_CTRL_RELOCK_EN
    localparam state_t c_fail_state = RESET_HOLD;
    localparam logic   c_relock_en  = 1'b1;
`else
    localparam state_t c_fail_state = HALT;
    localparam logic   c_relock_en  = 1'b0;
`endif

    state_t             r_state,     w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt,       w_cnt_nxt;
    logic               r_armed,     w_armed_nxt;
    logic               r_stepped,   w_stepped_nxt;
    adj_code_t          r_tgt_psda,  w_tgt_psda_nxt;
    adj_code_t          r_tgt_duty,  w_tgt_duty_nxt;
    adj_code_t          r_tgt_fdly,  w_tgt_fdly_nxt;
    adj_code_t          r_psda,      w_psda_nxt;
    adj_code_t          r_duty,      w_duty_nxt;
    adj_code_t          r_fdly,      w_fdly_nxt;
    logic               r_ack,       w_ack_nxt;
    logic [7:0]         r_relock,    w_relock_nxt;
    logic               r_timeout,   w_timeout_nxt;
    logic               r_pll_reset;
    logic               r_ready;
    logic               r_busy;

    logic w_lock_s;
    logic w_lock_ok;

    pll_lock_filter #(
        .LOCK_STABLE (LOCK_STABLE)
    ) u_lock_filter (
        .clk        (clk),
        .rst        (reset),
        .i_lock     (pll_lock),
        .i_count_en (r_state == WAIT_LOCK),
        .o_lock_s   (w_lock_s),
        .o_lock_ok  (w_lock_ok)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_armed_nxt    = r_armed | ~adj_if.adj_req;
        w_stepped_nxt  = r_stepped;
        w_tgt_psda_nxt = r_tgt_psda;
        w_tgt_duty_nxt = r_tgt_duty;
        w_tgt_fdly_nxt = r_tgt_fdly;
        w_psda_nxt     = r_psda;
        w_duty_nxt     = r_duty;
        w_fdly_nxt     = r_fdly;
        w_ack_nxt      = 1'b0;
        w_relock_nxt   = r_relock;
        w_timeout_nxt  = r_timeout;

        case (r_state)
            RESET_HOLD: begin
                if (r_cnt == c_reset_last) begin
                    w_state_nxt = WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            WAIT_LOCK: begin
                if (w_lock_ok) begin
                    w_state_nxt = RUN;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_timeout_last) begin
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = c_fail_state;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            RUN: begin
                // Lock loss takes priority over a simultaneous request.
                if (!w_lock_s) begin
                    w_state_nxt = c_fail_state;
                    w_cnt_nxt   = '0;
                    if (c_relock_en && (r_relock != 8'hFF)) w_relock_nxt = r_relock + 8'd1;
                end else if (adj_if.adj_req && r_armed) begin
                    w_tgt_psda_nxt = adj_if.adj_psda;
                    w_tgt_duty_nxt = clamp_duty(adj_if.adj_dutyda);
                    w_tgt_fdly_nxt = adj_if.adj_fdly;
                    w_armed_nxt    = 1'b0;
                    w_stepped_nxt  = 1'b0;
                    w_state_nxt    = STEP;
                    w_cnt_nxt      = '0;
                end
            end
            STEP: begin
                // Abort keeps whatever codes were already applied.
                if (!w_lock_s) begin
                    w_state_nxt = c_fail_state;
                    w_cnt_nxt   = '0;
                    if (c_relock_en && (r_relock != 8'hFF)) w_relock_nxt = r_relock + 8'd1;
                end else if (r_stepped && (r_psda == r_tgt_psda) && (r_duty == r_tgt_duty)) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = RUN;
                end else if (r_cnt == c_step_last) begin
                    w_cnt_nxt     = '0;
                    w_stepped_nxt = 1'b1;
                    w_fdly_nxt    = r_tgt_fdly;
                    w_duty_nxt    = duty_step(r_duty, r_tgt_duty);
                    if (r_psda != r_tgt_psda) w_psda_nxt = r_psda + adj_code_t'(1);
                end else begin
                    w_cnt_nxt = r_cnt + c_cnt_w'(1);
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = RESET_HOLD;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RESET_HOLD;
            r_cnt       <= '0;
            r_armed     <= 1'b1;
            r_stepped   <= 1'b0;
            r_tgt_psda  <= PSDA_INIT;
            r_tgt_duty  <= DUTYDA_INIT;
            r_tgt_fdly  <= FDLY_INIT;
            r_psda      <= PSDA_INIT;
            r_duty      <= DUTYDA_INIT;
            r_fdly      <= FDLY_INIT;
            r_ack       <= 1'b0;
            r_relock    <= 8'd0;
            r_timeout   <= 1'b0;
            r_pll_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_armed     <= w_armed_nxt;
            r_stepped   <= w_stepped_nxt;
            r_tgt_psda  <= w_tgt_psda_nxt;
            r_tgt_duty  <= w_tgt_duty_nxt;
            r_tgt_fdly  <= w_tgt_fdly_nxt;
            r_psda      <= w_psda_nxt;
            r_duty      <= w_duty_nxt;
            r_fdly      <= w_fdly_nxt;
            r_ack       <= w_ack_nxt;
            r_relock    <= w_relock_nxt;
            r_timeout   <= w_timeout_nxt;
            r_pll_reset <= (w_state_nxt == RESET_HOLD) || (w_state_nxt == HALT);
            r_ready     <= (w_state_nxt == RUN) || (w_state_nxt == STEP);
            r_busy      <= (w_state_nxt == STEP);
        end
    end

    assign pll_reset       = r_pll_reset;
    assign pll_psda        = r_psda;
    assign pll_dutyda      = r_duty;
    assign pll_fdly        = r_fdly;
    assign ready           = r_ready;
    assign relock_cnt      = r_relock;
    assign timeout_err     = r_timeout;
    assign adj_if.adj_busy = r_busy;
    assign adj_if.adj_ack  = r_ack;

endmodule
`default_nettype wire

// File: tb/tb_pll_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pll_ctrl
// Description : Self-checking bench for pll_ctrl (reset, lock, stepping, abort, timeout).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pll_ctrl;
    import pll_ctrl_pkg::*;

    localparam int c_rst_cyc = 16;
    localparam int c_stable  = 32;
    localparam int c_timeout = 300;
    localparam int c_step    = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       pll_reset;
    adj_code_t  pll_psda, pll_dutyda, pll_fdly;
    logic       ready;
    logic [7:0] relock_cnt;
    logic       timeout_err;

    pll_ctrl_if adj_bus ();

    pll_ctrl #(
        .RESET_CYCLES (c_rst_cyc),
        .LOCK_STABLE  (c_stable),
        .LOCK_TIMEOUT (c_timeout),
        .STEP_CYCLES  (c_step),
        .PSDA_INIT    (4'd0),
        .DUTYDA_INIT  (4'd8),
        .FDLY_INIT    (4'd0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pll_lock    (pll_lock),
        .pll_reset   (pll_reset),
        .pll_psda    (pll_psda),
        .pll_dutyda  (pll_dutyda),
        .pll_fdly    (pll_fdly),
        .ready       (ready),
        .adj_if      (adj_bus),
        .relock_cnt  (relock_cnt),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        adj_code_t psda;
        adj_code_t duty;
        adj_code_t fdly;
    } vec_t;

    typedef struct {
        adj_code_t tp, td, tf;
        adj_code_t fp, fd;
    } tv_t;

    vec_t      exp_q[$];
    adj_code_t m_psda, m_duty, m_fdly;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected code after every step, pushed when the request is driven.
    task automatic push_steps(input adj_code_t tp, input adj_code_t td, input adj_code_t tf);
        adj_code_t tdc = (td == 4'd0) ? 4'd1 : td;
        adj_code_t p = m_psda;
        adj_code_t d = m_duty;
        do begin
            if (p != tp) p = p + 4'd1;
            if (d < tdc) d = d + 4'd1;
            else if (d > tdc) d = d - 4'd1;
            exp_q.push_back('{psda: p, duty: d, fdly: tf});
        end while ((p != tp) || (d != tdc));
        m_psda = p;
        m_duty = d;
        m_fdly = tf;
    endtask

    task automatic do_adjust(input adj_code_t tp, input adj_code_t td, input adj_code_t tf);
        int   n;
        int   bad;
        vec_t e;
        vec_t prev;
        prev = '{psda: m_psda, duty: m_duty, fdly: m_fdly};
        push_steps(tp, td, tf);
        adj_bus.adj_req    = 1'b1;
        adj_bus.adj_psda   = tp;
        adj_bus.adj_dutyda = td;
        adj_bus.adj_fdly   = tf;
        n = 0;
        while (!adj_bus.adj_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("accept_busy", adj_bus.adj_busy, 1);
        check("accept_ready", ready, 1);
        if (!adj_bus.adj_busy) begin
            exp_q.delete();
            adj_bus.adj_req = 1'b0;
            return;
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            repeat (c_step - 1) @(negedge clk);
            check("pre_step_psda", pll_psda, prev.psda);
            check("pre_step_duty", pll_dutyda, prev.duty);
            @(negedge clk);
            check("step_psda", pll_psda, e.psda);
            check("step_duty", pll_dutyda, e.duty);
            check("step_fdly", pll_fdly, e.fdly);
            prev = e;
        end
        @(negedge clk);
        check("ack_pulse", adj_bus.adj_ack, 1);
        check("ack_busy_low", adj_bus.adj_busy, 0);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (adj_bus.adj_ack || adj_bus.adj_busy) bad++;
        end
        check("no_reaccept", bad, 0);
        adj_bus.adj_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        tv_t tbl[5];
        int  hi_cnt;
        int  rdy_at;
        int  lo;
        int  hi;
        int  bad;
        int  n;

        tbl[0] = '{tp: 4'd14, td: 4'd8,  tf: 4'd3, fp: 4'd14, fd: 4'd8};
        tbl[1] = '{tp: 4'd1,  td: 4'd6,  tf: 4'd5, fp: 4'd1,  fd: 4'd6};
        tbl[2] = '{tp: 4'd1,  td: 4'd0,  tf: 4'd5, fp: 4'd1,  fd: 4'd1};
        tbl[3] = '{tp: 4'd3,  td: 4'd10, tf: 4'd0, fp: 4'd3,  fd: 4'd10};
        tbl[4] = '{tp: 4'd3,  td: 4'd10, tf: 4'd0, fp: 4'd3,  fd: 4'd10};

        adj_bus.adj_req    = 1'b0;
        adj_bus.adj_psda   = 4'd0;
        adj_bus.adj_dutyda = 4'd0;
        adj_bus.adj_fdly   = 4'd0;
        m_psda = 4'd0; m_duty = 4'd8; m_fdly = 4'd0;

        // Reset values
        repeat (4) @(negedge clk);
        check("rst_pll_reset", pll_reset, 1);
        check("rst_ready", ready, 0);
        check("rst_busy", adj_bus.adj_busy, 0);
        check("rst_ack", adj_bus.adj_ack, 0);
        check("rst_relock", relock_cnt, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_psda", pll_psda, 0);
        check("rst_duty", pll_dutyda, 8);
        check("rst_fdly", pll_fdly, 0);

        // Power-up: lock appears 20 cycles after release
        reset  = 1'b0;
        hi_cnt = 0;
        rdy_at = -1;
        for (int k = 0; k < 80; k++) begin
            if (k == 20) pll_lock = 1'b1;
            if (pll_reset && (k == hi_cnt)) hi_cnt++;
            if (ready && (rdy_at < 0)) rdy_at = k;
            @(negedge clk);
        end
        check("pwr_reset_width", hi_cnt, c_rst_cyc);
        check("pwr_ready_cycle", rdy_at, 20 + 3 + c_stable);
        check("pwr_psda", pll_psda, 0);
        check("pwr_duty", pll_dutyda, 8);

        // Table-driven adjustments: walk, phase wrap, duty clamp, no-move
        for (int i = 0; i < 5; i++) begin
            do_adjust(tbl[i].tp, tbl[i].td, tbl[i].tf);
            check("tbl_final_psda", pll_psda, tbl[i].fp);
            check("tbl_final_duty", pll_dutyda, tbl[i].fd);
            check("tbl_final_fdly", pll_fdly, tbl[i].tf);
        end

        // Lock drop during STEP after two phase steps
        adj_bus.adj_req    = 1'b1;
        adj_bus.adj_psda   = 4'd12;
        adj_bus.adj_dutyda = 4'd10;
        adj_bus.adj_fdly   = 4'd7;
        n = 0;
        while (!adj_bus.adj_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("abort_accept", adj_bus.adj_busy, 1);
        repeat (2 * c_step) @(negedge clk);
        check("abort_psda_pre", pll_psda, 5);
        @(negedge clk);
        pll_lock = 1'b0;
        @(negedge clk);
        check("abort_ready_c1", ready, 1);
        @(negedge clk);
        check("abort_ready_c2", ready, 1);
        @(negedge clk);
        check("abort_ready_c3", ready, 0);
        check("abort_pll_reset", pll_reset, 1);
        check("abort_busy", adj_bus.adj_busy, 0);
        bad = 0;
        repeat (40) begin
            if (adj_bus.adj_ack) bad++;
            @(negedge clk);
        end
        check("abort_no_ack", bad, 0);
        check("abort_psda_kept", pll_psda, 5);
        check("abort_duty_kept", pll_dutyda, 10);
        check("abort_fdly_kept", pll_fdly, 7);
`ifdef PLL_CTRL_RELOCK_EN
        check("abort_relock_cnt", relock_cnt, 1);
`else
        check("abort_relock_cnt", relock_cnt, 0);
`endif
        adj_bus.adj_req = 1'b0;
        @(negedge clk);
        m_psda = 4'd5; m_duty = 4'd10; m_fdly = 4'd7;

        // Recovery, then a request raised before ready stays pending
`ifdef PLL_CTRL_RELOCK_EN
        pll_lock = 1'b1;
        check("relock_not_ready", ready, 0);
        do_adjust(4'd8, 4'd5, 4'd2);
        check("relock_cnt_hold", relock_cnt, 1);
`else
        pll_lock = 1'b1;
        bad = 0;
        repeat (60) begin
            @(negedge clk);
            if (ready || !pll_reset) bad++;
        end
        check("halt_stays", bad, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("halt_reset_psda", pll_psda, 0);
        reset = 1'b0;
        m_psda = 4'd0; m_duty = 4'd8; m_fdly = 4'd0;
        do_adjust(4'd8, 4'd5, 4'd2);
`endif
        check("pending_psda", pll_psda, 8);
        check("pending_duty", pll_dutyda, 5);

        // Lock never arrives: timeout
        pll_lock = 1'b0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        check("to_rst_timeout", timeout_err, 0);
        reset = 1'b0;
        n = 0;
        while (pll_reset && n < 100) begin
            @(negedge clk);
            n++;
        end
        lo = 0;
        while (!pll_reset && lo < 1000) begin
            lo++;
            @(negedge clk);
        end
        check("to_wait_len", lo, c_timeout);
        check("to_err_set", timeout_err, 1);
        check("to_ready", ready, 0);
        hi = 0;
        while (pll_reset && hi < 100) begin
            hi++;
            @(negedge clk);
        end
`ifdef PLL_CTRL_RELOCK_EN
        check("to_new_pulse", hi, c_rst_cyc);
`else
        check("to_halt_hold", hi, 100);
`endif
        check("to_err_sticky", timeout_err, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
